jstk2_spi_reader: RTL and testbench

Polls the Pmod JSTK2 joystick over SPI at a fixed rate. Each poll reads a 5-byte packet and decodes it into 10-bit X/Y positions and two button bits. It sits directly upstream of the LED indicator stage and feeds its `xpos`, `ypos` and `button` inputs. Outputs are registered and update atomically once per completed packet.

---
 rtl/jstk2_spi_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_jstk2_spi_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jstk2_spi_reader.sv
// Periodic SPI poller for the Pmod JSTK2: reads a 5-byte packet and presents X/Y/buttons atomically.
// Define JSTK2_RGB_CMD_EN to add led_r/led_g/led_b inputs and send the RGB LED command on MOSI.
module jstk2_spi_reader #(
   parameter int CLK_DIV     = 6,
   parameter int SS_SETUP    = 180,
   parameter int BYTE_GAP    = 120,
   parameter int POLL_PERIOD = 120000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       miso,
`ifdef JSTK2_RGB_CMD_EN
   input  logic [7:0] led_r,
   input  logic [7:0] led_g,
   input  logic [7:0] led_b,
`endif
   output logic       sclk,
   output logic       mosi,
   output logic       ss_n,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [1:0] button,
   output logic       data_valid
);

   localparam int POLL_W  = $clog2(POLL_PERIOD);
   localparam int TMR_MAX = (SS_SETUP > BYTE_GAP)
                            ? ((SS_SETUP > CLK_DIV) ? SS_SETUP : CLK_DIV)
                            : ((BYTE_GAP > CLK_DIV) ? BYTE_GAP : CLK_DIV);
   localparam int TMR_W   = $clog2(TMR_MAX);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [2:0]          byte_idx_q, byte_idx_d;
   logic                sclk_q, sclk_d;
   logic                ss_n_q, ss_n_d;
   logic                miso_s1_q, miso_s1_d;
   logic                miso_s2_q, miso_s2_d;
   logic [7:0]          shift_q, shift_d;
   logic [9:0]          stage_x_q, stage_x_d;
   logic [9:0]          stage_y_q, stage_y_d;
   logic [1:0]          stage_btn_q, stage_btn_d;
   logic [9:0]          xpos_q, xpos_d;
   logic [9:0]          ypos_q, ypos_d;
   logic [1:0]          button_q, button_d;
   logic                data_valid_q, data_valid_d;
`ifdef JSTK2_RGB_CMD_EN
   logic [7:0]          led_r_q, led_r_d;
   logic [7:0]          led_g_q, led_g_d;
   logic [7:0]          led_b_q, led_b_d;
   logic                mosi_q, mosi_d;
   logic [7:0]          tx_byte;
`endif

   always_comb begin
      state_d      = state_q;
      poll_cnt_d   = (poll_cnt_q == POLL_W'(POLL_PERIOD - 1)) ? '0 : poll_cnt_q + 1'b1;
      tmr_d        = tmr_q + 1'b1;
      bit_cnt_d    = bit_cnt_q;
      byte_idx_d   = byte_idx_q;
      sclk_d       = sclk_q;
      ss_n_d       = ss_n_q;
      miso_s1_d    = miso;
      miso_s2_d    = miso_s1_q;
      shift_d      = shift_q;
      stage_x_d    = stage_x_q;
      stage_y_d    = stage_y_q;
      stage_btn_d  = stage_btn_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      button_d     = button_q;
      data_valid_d = 1'b0;
`ifdef JSTK2_RGB_CMD_EN
      led_r_d      = led_r_q;
      led_g_d      = led_g_q;
      led_b_d      = led_b_q;
`endif

      case (state_q)
         ST_IDLE: begin
            tmr_d = '0;
            // Poll counter free-runs, so successive transaction starts stay exactly one period apart
            if (poll_cnt_q == POLL_W'(POLL_PERIOD - 1)) begin
               state_d = ST_SETUP;
               ss_n_d  = 1'b0;
`ifdef JSTK2_RGB_CMD_EN
               led_r_d = led_r;
               led_g_d = led_g;
               led_b_d = led_b;
`endif
            end
         end
         ST_SETUP: begin
            if (tmr_q == TMR_W'(SS_SETUP - 1)) begin
               state_d    = ST_SHIFT;
               tmr_d      = '0;
               byte_idx_d = 3'd0;
               bit_cnt_d  = 3'd7;
               sclk_d     = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (tmr_q == TMR_W'(CLK_DIV - 1)) begin
               tmr_d = '0;
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[6:0], miso_s2_q};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == 3'd0) begin
                     case (byte_idx_q)
                        3'd0:    stage_x_d[7:0] = shift_q;
                        3'd1:    stage_x_d[9:8] = shift_q[1:0];
                        3'd2:    stage_y_d[7:0] = shift_q;
                        3'd3:    stage_y_d[9:8] = shift_q[1:0];
                        default: stage_btn_d    = shift_q[1:0];
                     endcase
                     state_d = (byte_idx_q == 3'd4) ? ST_DONE : ST_GAP;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
         end
         ST_GAP: begin
            if (tmr_q == TMR_W'(BYTE_GAP - 1)) begin
               state_d    = ST_SHIFT;
               tmr_d      = '0;
               byte_idx_d = byte_idx_q + 3'd1;
               bit_cnt_d  = 3'd7;
            end
         end
         ST_DONE: begin
            // ss_n releases one cycle before the commit so data_valid lands just after the rise
            if (tmr_q == TMR_W'(CLK_DIV - 2)) begin
               ss_n_d = 1'b1;
            end
            if (tmr_q == TMR_W'(CLK_DIV - 1)) begin
               state_d      = ST_IDLE;
               tmr_d        = '0;
               xpos_d       = stage_x_q;
               ypos_d       = stage_y_q;
               button_d     = stage_btn_q;
               data_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            ss_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase

`ifdef JSTK2_RGB_CMD_EN
      case (byte_idx_d)
         3'd0:    tx_byte = 8'h84;
         3'd1:    tx_byte = led_r_q;
         3'd2:    tx_byte = led_g_q;
         3'd3:    tx_byte = led_b_q;
         default: tx_byte = 8'h00;
      endcase
      mosi_d = (state_d == ST_SHIFT) ? tx_byte[bit_cnt_d] : 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         poll_cnt_q   <= '0;
         tmr_q        <= '0;
         bit_cnt_q    <= '0;
         byte_idx_q   <= '0;
         sclk_q       <= 1'b0;
         ss_n_q       <= 1'b1;
         miso_s1_q    <= 1'b0;
         miso_s2_q    <= 1'b0;
         shift_q      <= '0;
         stage_x_q    <= 10'd512;
         stage_y_q    <= 10'd512;
         stage_btn_q  <= '0;
         xpos_q       <= 10'd512;
         ypos_q       <= 10'd512;
         button_q     <= '0;
         data_valid_q <= 1'b0;
`ifdef JSTK2_RGB_CMD_EN
         led_r_q      <= '0;
         led_g_q      <= '0;
         led_b_q      <= '0;
         mosi_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         poll_cnt_q   <= poll_cnt_d;
         tmr_q        <= tmr_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_idx_q   <= byte_idx_d;
         sclk_q       <= sclk_d;
         ss_n_q       <= ss_n_d;
         miso_s1_q    <= miso_s1_d;
         miso_s2_q    <= miso_s2_d;
         shift_q      <= shift_d;
         stage_x_q    <= stage_x_d;
         stage_y_q    <= stage_y_d;
         stage_btn_q  <= stage_btn_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         button_q     <= button_d;
         data_valid_q <= data_valid_d;
`ifdef JSTK2_RGB_CMD_EN
         led_r_q      <= led_r_d;
         led_g_q      <= led_g_d;
         led_b_q      <= led_b_d;
         mosi_q       <= mosi_d;
`endif
      end
   end

   assign sclk       = sclk_q;
   assign ss_n       = ss_n_q;
   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign button     = button_q;
   assign data_valid = data_valid_q;
`ifdef JSTK2_RGB_CMD_EN
   assign mosi       = mosi_q;
`else
   assign mosi       = 1'b0;
`endif

endmodule

// File: tb/tb_jstk2_spi_reader.sv
// Bench for jstk2_spi_reader: SPI slave model, table of packets, timing and mid-transaction reset checks.
module tb_jstk2_spi_reader;

   localparam int CLK_DIV  = 6;
   localparam int SS_SETUP = 180;
   localparam int BYTE_GAP = 120;
   localparam int POLL     = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       miso;
   logic       sclk, mosi, ss_n, data_valid;
   logic [9:0] xpos, ypos;
   logic [1:0] button;
`ifdef JSTK2_RGB_CMD_EN
   logic [7:0] led_r = 8'h11;
   logic [7:0] led_g = 8'h22;
   logic [7:0] led_b = 8'h33;
`endif

   jstk2_spi_reader #(
      .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(BYTE_GAP), .POLL_PERIOD(POLL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .miso(miso),
`ifdef JSTK2_RGB_CMD_EN
      .led_r(led_r), .led_g(led_g), .led_b(led_b),
`endif
      .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
      .xpos(xpos), .ypos(ypos), .button(button), .data_valid(data_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   // SPI slave, mode 0: shifts the next bit out on each sclk fall, bit 0 ready at ss_n fall
   logic [39:0] pkt_bits = '0;
   int          sl_bit = 0;
   assign miso = (sl_bit < 40) ? pkt_bits[39 - sl_bit] : 1'b0;
   always @(posedge ss_n or negedge sclk) begin
      if (ss_n) sl_bit = 0;
      else      sl_bit++;
   end

   // MOSI capture and sclk period tracking within each byte
   logic [39:0] mosi_sr = '0;
   int          rise_cnt = 0;
   int          pmin = 0;
   int          pmax = 0;
   time         last_rise = 0;
   always @(negedge ss_n or posedge sclk) begin
      if (sclk) begin
         if (rise_cnt % 8 != 0) begin
            if (int'(($time - last_rise) / 10) < pmin) pmin = int'(($time - last_rise) / 10);
            if (int'(($time - last_rise) / 10) > pmax) pmax = int'(($time - last_rise) / 10);
         end
         last_rise = $time;
         rise_cnt++;
         mosi_sr = {mosi_sr[38:0], mosi};
      end else begin
         rise_cnt = 0;
         mosi_sr  = '0;
         pmin     = 1000000;
         pmax     = 0;
      end
   end

   int dv_cnt = 0;
   always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

   typedef struct {
      logic [39:0] pkt;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [1:0]  btn;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_fall(input int budget, output int waited);
      waited = 0;
      while (ss_n !== 1'b0 && waited < budget) begin
         @(posedge clk); #1;
         waited++;
      end
   endtask

   // Called just after ss_n has been seen low; runs to one cycle past the commit
   task automatic finish_txn(input int idx, input vec_t v, input logic [9:0] px,
                             input logic [9:0] py, input logic [1:0] pb,
                             input logic [39:0] exp_mosi);
      int dur;
      chk("sclk_at_fall", sclk, 0);
      dur = 0;
      while (ss_n === 1'b0 && dur < 3000) begin
         @(posedge clk); #1;
         dur++;
      end
      chk("ss_low_cycles", dur, 1145);
      chk("sclk_at_rise", sclk, 0);
      chk("hold_xpos", xpos, px);
      chk("hold_ypos", ypos, py);
      chk("hold_button", button, pb);
      chk("dv_before_commit", data_valid, 0);
      @(posedge clk); #1;
      chk("dv_commit", data_valid, 1);
      chk("xpos", xpos, v.x);
      chk("ypos", ypos, v.y);
      chk("button", button, v.btn);
      @(posedge clk); #1;
      chk("dv_after_commit", data_valid, 0);
      chk("sclk_rises", rise_cnt, 40);
      chk("sclk_period_min", pmin, 2 * CLK_DIV);
      chk("sclk_period_max", pmax, 2 * CLK_DIV);
      chk("mosi_bytes", mosi_sr, exp_mosi);
      $display("txn %0d pkt=%010h xpos=%0d ypos=%0d button=%b mosi=%010h ss_low=%0d",
               idx, v.pkt, xpos, ypos, button, mosi_sr, dur);
   endtask

   initial begin
      int          w;
      int          n;
      int          last_fall;
      int          dv_before;
      logic [39:0] exp_m;
      vec_t        ab;

      vecs[0] = '{pkt: 40'h2C01900102, x: 10'd300,  y: 10'd400, btn: 2'b10};
      vecs[1] = '{pkt: 40'hFFFF00FC03, x: 10'd1023, y: 10'd0,   btn: 2'b11};
      vecs[2] = '{pkt: 40'h0000000000, x: 10'd0,    y: 10'd0,   btn: 2'b00};
      vecs[3] = '{pkt: 40'h5503AA0201, x: 10'd853,  y: 10'd682, btn: 2'b01};
      vecs[4] = '{pkt: 40'h80FE7F0DFE, x: 10'd640,  y: 10'd383, btn: 2'b10};
      ab      = '{pkt: 40'hA1B2C3D4E5, x: 10'd673,  y: 10'd195, btn: 2'b01};

      pkt_bits = vecs[0].pkt;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ss_n", ss_n, 1);
      chk("rst_xpos", xpos, 512);
      chk("rst_ypos", ypos, 512);
      chk("rst_button", button, 0);
      chk("rst_data_valid", data_valid, 0);

      @(negedge clk) rst_n = 1'b1;
      wait_fall(5000, w);
      chk("first_fall_delay", w, POLL);
      last_fall = cyc;

      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            wait_fall(5000, w);
            chk("fall_spacing", cyc - last_fall, POLL);
            last_fall = cyc;
         end
`ifdef JSTK2_RGB_CMD_EN
         exp_m = {8'h84, led_r, led_g, led_b, 8'h00};
         if (i == 2) begin
            fork
               begin
                  repeat (300) @(posedge clk);
                  led_g = 8'h99;
               end
            join_none
         end
`else
         exp_m = '0;
`endif
         finish_txn(i, vecs[i],
                    (i == 0) ? 10'd512 : vecs[(i == 0) ? 0 : i - 1].x,
                    (i == 0) ? 10'd512 : vecs[(i == 0) ? 0 : i - 1].y,
                    (i == 0) ? 2'b00   : vecs[(i == 0) ? 0 : i - 1].btn,
                    exp_m);
         pkt_bits = (i < 4) ? vecs[(i < 4) ? i + 1 : 0].pkt : ab.pkt;
      end

      // Reset during byte 2, then a full transaction after release
      wait_fall(5000, w);
      chk("abort_fall_spacing", cyc - last_fall, POLL);
      n = 0;
      while (sl_bit < 18 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_in_byte2", (sl_bit >= 16 && sl_bit < 24) ? 1 : 0, 1);
      @(negedge clk) rst_n = 1'b0;
      #1;
      dv_before = dv_cnt;
      chk("abort_ss_n", ss_n, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_xpos", xpos, 512);
      chk("abort_ypos", ypos, 512);
      chk("abort_button", button, 0);
      chk("abort_dv", data_valid, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_fall(5000, w);
      chk("abort_restart_delay", w, POLL);
      chk("abort_no_dv", dv_cnt, dv_before);
`ifdef JSTK2_RGB_CMD_EN
      exp_m = {8'h84, led_r, led_g, led_b, 8'h00};
`else
      exp_m = '0;
`endif
      finish_txn(5, ab, 10'd512, 10'd512, 2'b00, exp_m);
      chk("dv_total", dv_cnt, dv_before + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
